// File: rtl/sipo_pkg.sv
// rtl/sipo_pkg.sv - shared state encoding for the serial-in/parallel-out deserializer
package sipo_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } state_t;

endpackage

// File: rtl/sipo_deser.sv
// rtl/sipo_deser.sv - serial-in/parallel-out deserializer with sync framing
module sipo_deser
    import sipo_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sen,
    input  logic             sync,
    input  logic             clr,
    output logic [WIDTH-1:0] pout,
    output logic             pvalid,
    output logic             busy,
    output logic             err
);

    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nx;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_nx;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_nx;
    logic [WIDTH-1:0] pout_nx;
    logic             pvalid_nx;
    logic             err_nx;

    // shifted: partial word with sin appended; first_word: sin as the only bit of a fresh frame
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] first_word;

    generate
        if (MSB_FIRST) begin : g_msb_first
            // Shift left so the earliest bit migrates toward pout[WIDTH-1]
            always_comb begin
                shifted    = {shreg[WIDTH-2:0], sin};
                first_word = {{(WIDTH-1){1'b0}}, sin};
            end
        end else begin : g_lsb_first
            // Shift right so the earliest bit migrates toward pout[0]
            always_comb begin
                shifted    = {sin, shreg[WIDTH-1:1]};
                first_word = {sin, {(WIDTH-1){1'b0}}};
            end
        end
    endgenerate

    // Next-state, counter, shift register and output-register decisions
    always_comb begin
        state_nx  = state;
        count_nx  = count;
        shreg_nx  = shreg;
        pout_nx   = pout;
        pvalid_nx = 1'b0;
        err_nx    = 1'b0;

        if (clr) begin
            // Abort wins over any bit presented in the same cycle; last word stays visible
            state_nx = ST_IDLE;
            count_nx = '0;
            shreg_nx = '0;
        end else if (sen) begin
            unique case (state)
                ST_IDLE: begin
                    // Without sync there is no frame alignment, so the bit is dropped
                    if (sync) begin
                        state_nx = ST_RECV;
                        count_nx = CW'(1);
                        shreg_nx = first_word;
                    end
                end
                ST_RECV: begin
                    if (sync) begin
                        // Resynchronise: partial word lost, this bit starts the new frame
                        count_nx = CW'(1);
                        shreg_nx = first_word;
                        err_nx   = 1'b1;
                    end else if (count == LAST_BIT) begin
                        // Final bit: publish the word and return to IDLE so a sync
                        // on the very next cycle is accepted
                        state_nx  = ST_IDLE;
                        count_nx  = '0;
                        shreg_nx  = '0;
                        pout_nx   = shifted;
                        pvalid_nx = 1'b1;
                    end else begin
                        count_nx = count + CW'(1);
                        shreg_nx = shifted;
                    end
                end
                default: begin
                    state_nx = ST_IDLE;
                    count_nx = '0;
                    shreg_nx = '0;
                end
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Bit counter within the current frame
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else begin
            count <= count_nx;
        end
    end

    // Shift register holding the partially assembled word
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg <= '0;
        end else begin
            shreg <= shreg_nx;
        end
    end

    // Output register and single-cycle status strobes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pout   <= '0;
            pvalid <= 1'b0;
            err    <= 1'b0;
        end else begin
            pout   <= pout_nx;
            pvalid <= pvalid_nx;
            err    <= err_nx;
        end
    end

    assign busy = (state == ST_RECV);

endmodule

// File: tb/tb_sipo_deser.sv
// tb/tb_sipo_deser.sv - directed self-checking bench for sipo_deser
module tb_sipo_deser;

    logic       clk;
    logic       rst;
    logic       sin;
    logic       sen;
    logic       sync;
    logic       clr;
    logic [3:0] pout;
    logic       pvalid;
    logic       busy;
    logic       err;
    logic [3:0] pout_l;
    logic       pvalid_l;
    logic       busy_l;
    logic       err_l;

    int checks = 0;
    int errors = 0;

    sipo_deser #(.WIDTH(4), .MSB_FIRST(1'b1)) dut (
        .clk    (clk),
        .rst    (rst),
        .sin    (sin),
        .sen    (sen),
        .sync   (sync),
        .clr    (clr),
        .pout   (pout),
        .pvalid (pvalid),
        .busy   (busy),
        .err    (err)
    );

    sipo_deser #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
        .clk    (clk),
        .rst    (rst),
        .sin    (sin),
        .sen    (sen),
        .sync   (sync),
        .clr    (clr),
        .pout   (pout_l),
        .pvalid (pvalid_l),
        .busy   (busy_l),
        .err    (err_l)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, clock it in, then settle 1 time unit past the edge
    task automatic step(input logic b, input logic e, input logic s, input logic c);
        sin  = b;
        sen  = e;
        sync = s;
        clr  = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst  = 1'b0;
        sin  = 1'b0;
        sen  = 1'b0;
        sync = 1'b0;
        clr  = 1'b0;
        #1;

        // Reset held for two cycles, even with traffic on the inputs
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("rst_pout_0",   {28'd0, pout}, 32'h0);
        chk("rst_pvalid_0", {31'd0, pvalid}, 32'h0);
        chk("rst_busy_0",   {31'd0, busy}, 32'h0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("rst_pout_1",   {28'd0, pout}, 32'h0);
        chk("rst_busy_1",   {31'd0, busy}, 32'h0);
        chk("rst_err_1",    {31'd0, err}, 32'h0);
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("idle_busy", {31'd0, busy}, 32'h0);

        // Continuous frame 1,1,0,1
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("t2_busy_b0", {31'd0, busy}, 32'h1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("t2_busy_b1", {31'd0, busy}, 32'h1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("t2_busy_b2",   {31'd0, busy}, 32'h1);
        chk("t2_pvalid_b2", {31'd0, pvalid}, 32'h0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("t2_pout",   {28'd0, pout}, 32'hd);
        chk("t2_pvalid", {31'd0, pvalid}, 32'h1);
        chk("t2_busy_done", {31'd0, busy}, 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t2_pvalid_drop", {31'd0, pvalid}, 32'h0);
        chk("t2_pout_hold",   {28'd0, pout}, 32'hd);

        // Same frame with sen gaps; gaps carry junk on sin/sync
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t3_gap_busy", {31'd0, busy}, 32'h1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t3_gap_pvalid", {31'd0, pvalid}, 32'h0);
        chk("t3_gap_err",    {31'd0, err}, 32'h0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("t3_pvalid", {31'd0, pvalid}, 32'h1);
        chk("t3_pout",   {28'd0, pout}, 32'hd);

        // Resync mid-frame: 1,0,1 dropped, then 0,0,1,1 completes
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("t4_pre_err", {31'd0, err}, 32'h0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("t4_err",        {31'd0, err}, 32'h1);
        chk("t4_err_pvalid", {31'd0, pvalid}, 32'h0);
        chk("t4_err_busy",   {31'd0, busy}, 32'h1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("t4_err_drop", {31'd0, err}, 32'h0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("t4_pout_mid", {28'd0, pout}, 32'hd);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("t4_pvalid", {31'd0, pvalid}, 32'h1);
        chk("t4_pout",   {28'd0, pout}, 32'h3);

        // Back-to-back frames 1101 then 0110
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("t5_pvalid_a", {31'd0, pvalid}, 32'h1);
        chk("t5_pout_a",   {28'd0, pout}, 32'hd);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("t5_gap_pvalid", {31'd0, pvalid}, 32'h0);
        chk("t5_gap_err",    {31'd0, err}, 32'h0);
        chk("t5_gap_busy",   {31'd0, busy}, 32'h1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("t5_pvalid_mid", {31'd0, pvalid}, 32'h0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("t5_pvalid_b", {31'd0, pvalid}, 32'h1);
        chk("t5_pout_b",   {28'd0, pout}, 32'h6);

        // clr after two bits; clr cycle carries a sync bit that must be ignored
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        chk("t6_clr_busy",   {31'd0, busy}, 32'h0);
        chk("t6_clr_pvalid", {31'd0, pvalid}, 32'h0);
        chk("t6_clr_err",    {31'd0, err}, 32'h0);
        chk("t6_clr_pout",   {28'd0, pout}, 32'h6);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("t6_unaligned_busy", {31'd0, busy}, 32'h0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("t6_pvalid", {31'd0, pvalid}, 32'h1);
        chk("t6_pout",   {28'd0, pout}, 32'h9);
        chk("t6_lsb_pout_9", {28'd0, pout_l}, 32'h9);

        // 1,1,0,1 into both bit orders
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("t6_lsb_busy", {31'd0, busy_l}, 32'h1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("t6_msb_pout",   {28'd0, pout}, 32'hd);
        chk("t6_lsb_pout",   {28'd0, pout_l}, 32'hb);
        chk("t6_lsb_pvalid", {31'd0, pvalid_l}, 32'h1);
        chk("t6_lsb_err",    {31'd0, err_l}, 32'h0);

        // Asynchronous reset mid-frame takes effect without a clock edge
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("arst_pre_busy", {31'd0, busy}, 32'h1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'h0);
        chk("arst_pout", {28'd0, pout}, 32'h0);
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("arst_after_busy", {31'd0, busy}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
